// File: rtl/hrm_control.sv
// hrm_control: multi-cycle control FSM of the HRM CPU.
// Sequences fetch/decode/execute one instruction at a time and drives the
// datapath strobes, ALU select, PC update and inbox/outbox handshakes.
module hrm_control #(
  parameter bit INBOX_EMPTY_HALTS = 1'b1,
  parameter bit CHECK_R_VALID     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic       R_zero,
  input  logic       R_neg,
  input  logic       inbox_empty,
  input  logic       outbox_full,
  output logic       wIR,
  output logic       incPC,
  output logic       ldPC,
  output logic [1:0] muxR,
  output logic       wR,
  output logic       wM,
  output logic [1:0] aluCtl,
  output logic       inbox_rd,
  output logic       outbox_wr,
  output logic       halt,
  output logic       error
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_INWAIT,
    S_OUTWAIT,
    S_MEMRD,
    S_WB,
    S_MEMWR,
    S_JMP,
    S_INCPC,
    S_HALTED
  } state_t;

  state_t     state, state_next;
  logic       r_valid, r_valid_next;
  logic       error_q, error_next;
  logic [3:0] opcode;
  logic       is_alu;
  logic       is_bump;
  logic       needs_r;
  logic       operand_unused;

  assign opcode  = instr[7:4];
  // opcodes 4..7 (ADD, SUB, BUMPUP, BUMPDN) select the ALU; low two bits map to aluCtl
  assign is_alu  = (opcode[3:2] == 2'b01);
  assign is_bump = (opcode[3:1] == 3'b011);
  assign needs_r = (opcode == 4'h1) || (opcode == 4'h3) || (opcode == 4'h4) ||
                   (opcode == 4'h5) || (opcode == 4'h9) || (opcode == 4'hA);
  // operand bits are consumed by the datapath, not by control
  assign operand_unused = ^instr[3:0];

  assign error = error_q;

  // State, R-valid tracking and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      r_valid <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state   <= state_next;
      r_valid <= r_valid_next;
      error_q <= error_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next   = state;
    r_valid_next = r_valid;
    error_next   = error_q;
    wIR          = 1'b0;
    incPC        = 1'b0;
    ldPC         = 1'b0;
    muxR         = 2'b00;
    wR           = 1'b0;
    wM           = 1'b0;
    aluCtl       = 2'b00;
    inbox_rd     = 1'b0;
    outbox_wr    = 1'b0;
    halt         = 1'b0;

    unique case (state)
      S_FETCH: begin
        wIR        = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          4'h0:                      state_next = S_INWAIT;
          4'h1:                      state_next = S_OUTWAIT;
          4'h2, 4'h4, 4'h5, 4'h6,
          4'h7:                      state_next = S_MEMRD;
          4'h3:                      state_next = S_MEMWR;
          4'h8:                      state_next = S_JMP;
          4'h9:                      state_next = R_zero ? S_JMP : S_INCPC;
          4'hA:                      state_next = R_neg ? S_JMP : S_INCPC;
          4'hF:                      state_next = S_HALTED;
          default: begin
            state_next = S_HALTED;
            error_next = 1'b1;
          end
        endcase
        if (CHECK_R_VALID && !r_valid && needs_r) begin
          state_next = S_HALTED;
          error_next = 1'b1;
        end
      end
      S_INWAIT: begin
        if (!inbox_empty) begin
          wR           = 1'b1;
          inbox_rd     = 1'b1;
          r_valid_next = 1'b1;
          state_next   = S_INCPC;
        end else if (INBOX_EMPTY_HALTS) begin
          state_next = S_HALTED;
        end
      end
      S_OUTWAIT: begin
        if (!outbox_full) begin
          outbox_wr  = 1'b1;
          state_next = S_INCPC;
        end
      end
      S_MEMRD: begin
        aluCtl     = is_alu ? opcode[1:0] : 2'b00;
        state_next = S_WB;
      end
      S_WB: begin
        wR           = 1'b1;
        muxR         = is_alu ? 2'b11 : 2'b01;
        aluCtl       = is_alu ? opcode[1:0] : 2'b00;
        r_valid_next = 1'b1;
        state_next   = is_bump ? S_MEMWR : S_INCPC;
      end
      S_MEMWR: begin
        wM         = 1'b1;
        state_next = S_INCPC;
      end
      S_JMP: begin
        ldPC       = 1'b1;
        state_next = S_FETCH;
      end
      S_INCPC: begin
        incPC      = 1'b1;
        state_next = S_FETCH;
      end
      S_HALTED: begin
        halt = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    // reset drops any strobe of the interrupted cycle
    if (rst) begin
      wIR       = 1'b0;
      incPC     = 1'b0;
      ldPC      = 1'b0;
      muxR      = 2'b00;
      wR        = 1'b0;
      wM        = 1'b0;
      aluCtl    = 2'b00;
      inbox_rd  = 1'b0;
      outbox_wr = 1'b0;
    end
  end

endmodule

// File: tb/tb_hrm_control.sv
// tb_hrm_control: drives two hrm_control instances (empty inbox halts / waits)
// with directed and random instruction streams and compares every cycle
// against per-instruction expected output schedules.
module tb_hrm_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_s = 2'b11;
  logic [1:0] R_zero_s = '0, R_neg_s = '0, inbox_empty_s = '0, outbox_full_s = '0;
  logic [7:0] instr_s [2];
  logic [1:0] wIR_s, incPC_s, ldPC_s, wR_s, wM_s, inbox_rd_s, outbox_wr_s, halt_s, error_s;
  logic [1:0] muxR_s [2];
  logic [1:0] aluCtl_s [2];

  int tests = 0;
  int fails = 0;
  bit rv [2];
  bit halted [2];

  // output vector: wIR incPC ldPC muxR[1:0] wR wM aluCtl[1:0] inbox_rd outbox_wr halt error
  localparam logic [12:0] V_WIR   = 13'h1000;
  localparam logic [12:0] V_INC   = 13'h0800;
  localparam logic [12:0] V_LD    = 13'h0400;
  localparam logic [12:0] V_WR    = 13'h0080;
  localparam logic [12:0] V_WM    = 13'h0040;
  localparam logic [12:0] V_INRD  = 13'h0008;
  localparam logic [12:0] V_OUTWR = 13'h0004;
  localparam logic [12:0] V_HALT  = 13'h0002;
  localparam logic [12:0] V_ERR   = 13'h0001;
  localparam logic [12:0] KEEP    = 13'h0003;

  hrm_control #(.INBOX_EMPTY_HALTS(1'b1), .CHECK_R_VALID(1'b1)) u_halts (
    .clk(clk), .rst(rst_s[0]), .instr(instr_s[0]), .R_zero(R_zero_s[0]), .R_neg(R_neg_s[0]),
    .inbox_empty(inbox_empty_s[0]), .outbox_full(outbox_full_s[0]),
    .wIR(wIR_s[0]), .incPC(incPC_s[0]), .ldPC(ldPC_s[0]), .muxR(muxR_s[0]), .wR(wR_s[0]),
    .wM(wM_s[0]), .aluCtl(aluCtl_s[0]), .inbox_rd(inbox_rd_s[0]), .outbox_wr(outbox_wr_s[0]),
    .halt(halt_s[0]), .error(error_s[0])
  );

  hrm_control #(.INBOX_EMPTY_HALTS(1'b0), .CHECK_R_VALID(1'b1)) u_waits (
    .clk(clk), .rst(rst_s[1]), .instr(instr_s[1]), .R_zero(R_zero_s[1]), .R_neg(R_neg_s[1]),
    .inbox_empty(inbox_empty_s[1]), .outbox_full(outbox_full_s[1]),
    .wIR(wIR_s[1]), .incPC(incPC_s[1]), .ldPC(ldPC_s[1]), .muxR(muxR_s[1]), .wR(wR_s[1]),
    .wM(wM_s[1]), .aluCtl(aluCtl_s[1]), .inbox_rd(inbox_rd_s[1]), .outbox_wr(outbox_wr_s[1]),
    .halt(halt_s[1]), .error(error_s[1])
  );

  function automatic logic [12:0] obs(input int d);
    return {wIR_s[d], incPC_s[d], ldPC_s[d], muxR_s[d], wR_s[d], wM_s[d], aluCtl_s[d],
            inbox_rd_s[d], outbox_wr_s[d], halt_s[d], error_s[d]};
  endfunction

  function automatic logic [12:0] mux_v(input logic [1:0] m);
    return 13'(m) << 8;
  endfunction

  function automatic logic [12:0] alu_v(input logic [1:0] a);
    return 13'(a) << 4;
  endfunction

  task automatic check(input string tag, input logic [12:0] o, input logic [12:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic do_reset(input int d);
    rst_s[d] = 1'b1;
    #1;
    @(negedge clk);
    #1;
    check("reset_state", obs(d), 13'h0000);
    rst_s[d] = 1'b0;
    rv[d] = 1'b0;
    halted[d] = 1'b0;
  endtask

  // Builds the cycle-by-cycle expected schedule of one instruction from the
  // opcode rules, then plays it; abort_at injects reset at that cycle.
  task automatic do_instr(input int d, input logic [3:0] op, input logic rz, input logic rn,
                          input int waits, input int abort_at, input string tag);
    logic [12:0] exp_q [$];
    bit emp_q [$];
    bit full_q [$];
    bit r = rv[d];
    bit stop = 1'b0;
    logic [12:0] err = '0;
    logic [3:0] lo = 4'($urandom);

    exp_q.push_back(V_WIR); emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
    exp_q.push_back('0);    emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));

    if (op inside {[4'hB:4'hE]}) begin
      stop = 1'b1; err = V_ERR;
    end else if (op == 4'hF) begin
      stop = 1'b1;
    end else if ((op inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h9, 4'hA}) && !r) begin
      stop = 1'b1; err = V_ERR;
    end else begin
      case (op)
        4'h0: begin
          if (d == 0 && waits > 0) begin
            exp_q.push_back('0); emp_q.push_back(1'b1); full_q.push_back(1'($urandom));
            stop = 1'b1;
          end else begin
            repeat (waits) begin
              exp_q.push_back('0); emp_q.push_back(1'b1); full_q.push_back(1'($urandom));
            end
            exp_q.push_back(V_WR | V_INRD); emp_q.push_back(1'b0); full_q.push_back(1'($urandom));
            r = 1'b1;
            exp_q.push_back(V_INC); emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
          end
        end
        4'h1: begin
          repeat (waits) begin
            exp_q.push_back('0); emp_q.push_back(1'($urandom)); full_q.push_back(1'b1);
          end
          exp_q.push_back(V_OUTWR); emp_q.push_back(1'($urandom)); full_q.push_back(1'b0);
          exp_q.push_back(V_INC);   emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
        end
        4'h2: begin
          exp_q.push_back('0);                  emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
          exp_q.push_back(V_WR | mux_v(2'b01)); emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
          exp_q.push_back(V_INC);               emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
          r = 1'b1;
        end
        4'h3: begin
          exp_q.push_back(V_WM);  emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
          exp_q.push_back(V_INC); emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
        end
        4'h4, 4'h5, 4'h6, 4'h7: begin
          exp_q.push_back(alu_v(op[1:0])); emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
          exp_q.push_back(V_WR | mux_v(2'b11) | alu_v(op[1:0]));
          emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
          if (op >= 4'h6) begin
            exp_q.push_back(V_WM); emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
          end
          exp_q.push_back(V_INC); emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
          r = 1'b1;
        end
        4'h8: begin
          exp_q.push_back(V_LD); emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
        end
        4'h9: begin
          exp_q.push_back(rz ? V_LD : V_INC); emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
        end
        default: begin
          exp_q.push_back(rn ? V_LD : V_INC); emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
        end
      endcase
    end

    if (stop) begin
      repeat (2) begin
        exp_q.push_back(V_HALT | err); emp_q.push_back(1'($urandom)); full_q.push_back(1'($urandom));
      end
    end

    instr_s[d]  = {op, lo};
    R_zero_s[d] = rz;
    R_neg_s[d]  = rn;
    for (int i = 0; i < exp_q.size(); i++) begin
      inbox_empty_s[d] = emp_q[i];
      outbox_full_s[d] = full_q[i];
      if (i == abort_at) begin
        rst_s[d] = 1'b1;
        #1;
        check($sformatf("%s_abort[%0d]", tag, i), obs(d), exp_q[i] & KEEP);
        @(negedge clk);
        rst_s[d] = 1'b0;
        rv[d] = 1'b0;
        halted[d] = 1'b0;
        return;
      end
      #1;
      check($sformatf("%s[%0d]", tag, i), obs(d), exp_q[i]);
      @(negedge clk);
    end
    rv[d] = r;
    halted[d] = stop;
  endtask

  task automatic random_run(input int d, input int n);
    logic [3:0] op;
    int waits;
    int abort_at;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
      else op = 4'($urandom_range(0, 10));
      if (d == 0) waits = ($urandom_range(0, 5) == 0) ? 1 : 0;
      else waits = $urandom_range(0, 3);
      abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : -1;
      do_instr(d, op, 1'($urandom), 1'($urandom), waits, abort_at, "rand");
      if (halted[d]) do_reset(d);
    end
  endtask

  initial begin
    instr_s[0] = '0;
    instr_s[1] = '0;
    @(negedge clk);

    do_reset(0);
    do_instr(0, 4'h0, 1'b0, 1'b0, 0, -1, "t1_inbox");
    do_reset(0);
    do_instr(0, 4'h1, 1'b0, 1'b0, 0, -1, "t3_outbox_no_r");
    do_reset(0);
    do_instr(0, 4'h0, 1'b0, 1'b0, 0, -1, "t4_inbox");
    do_instr(0, 4'h6, 1'b0, 1'b0, 0, -1, "t4_bumpup");
    do_instr(0, 4'h9, 1'b1, 1'b0, 0, -1, "t5_jumpz_taken");
    do_instr(0, 4'h9, 1'b0, 1'b1, 0, -1, "t5_jumpz_untaken");
    do_instr(0, 4'hA, 1'b0, 1'b1, 0, -1, "jumpn_taken");
    do_instr(0, 4'h7, 1'b0, 1'b0, 0, -1, "bumpdn");
    do_instr(0, 4'h5, 1'b0, 1'b0, 0, -1, "sub");
    do_instr(0, 4'h3, 1'b0, 1'b0, 0, -1, "copyto");
    do_instr(0, 4'h2, 1'b0, 1'b0, 0, -1, "copyfrom");
    do_instr(0, 4'hC, 1'b0, 1'b0, 0, -1, "t5_illegal");
    do_reset(0);
    do_instr(0, 4'h0, 1'b0, 1'b0, 0, -1, "t6_inbox");
    do_instr(0, 4'h4, 1'b0, 1'b0, 0, 3, "t6_rst_in_wb");
    do_instr(0, 4'h8, 1'b0, 1'b0, 0, -1, "t6_after_rst");
    do_instr(0, 4'h9, 1'b1, 1'b0, 0, -1, "t6_r_cleared");
    do_reset(0);
    do_instr(0, 4'h0, 1'b0, 1'b0, 1, -1, "empty_halts");
    do_reset(0);
    do_instr(0, 4'hF, 1'b0, 1'b0, 0, -1, "halt_op");
    do_reset(0);
    random_run(0, 150);

    rst_s[0] = 1'b1;
    do_reset(1);
    do_instr(1, 4'h0, 1'b0, 1'b0, 5, -1, "t2_inwait");
    do_instr(1, 4'h1, 1'b0, 1'b0, 3, -1, "outwait");
    random_run(1, 150);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
